fpu_seq_ctrl: RTL and testbench
===============================

# fpu_seq_ctrl

Multi-cycle successor to the single-cycle core's main decoder. Integer instructions decode in one cycle. RV32F arithmetic (FADD.S/FSUB.S/FMUL.S/FDIV.S) goes through a start/ready/done handshake to a variable-latency FPU. While an FP op is outstanding the block stalls fetch, then issues a single FP writeback cycle. A parametrised watchdog aborts FP ops that never complete. The block sits between instruction fetch/decode and the datapath muxes, ALU, FPU and register file.

## Interface
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before abort; legal range ≥2.
- FPU_CTRL_W, 3: width of FPUControl.
- CNT_W, $clog2(TIMEOUT_CYCLES+1): watchdog counter width (derived).
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-low reset.
- instr_valid  in  1  op/funct3/funct7 hold a valid instruction.
- op  in  7  opcode.
- funct3  in  3  funct3 (rm for FP ops; ignored for FP decode).
- funct7  in  7  funct7.
- Zero  in  1  ALU zero flag.
- fpu_ready  in  1  FPU can accept an op.
- fpu_done  in  1  FPU result valid, one-cycle pulse.
- PCSrc  out  1  take branch.
- ResultSrc  out  1  1 = memory read data.
- MemWrite  out  1  store enable.
- ALUControl  out  3  ADD=000, SUB=001, AND=010, OR=011, SLT=101.
- ALUSrc  out  1  1 = immediate operand.
- ImmSrc  out  2  I=00, S=01, B=10.
- RegWrite  out  1  register-file write enable.
- FPUControl  out  FPU_CTRL_W  ADD=0, SUB=1, MUL=2, DIV=3.
- ALU_FPU_Select  out  1  1 = writeback from FPU.
- fpu_start  out  1  issue strobe to FPU.
- stall  out  1  hold PC and instruction register.
- illegal  out  1  undecodable instruction, one-cycle pulse.
- fpu_err  out  1  sticky watchdog abort flag.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WB. Reset state IDLE, counter 0, fpu_err 0.
- **IDLE, integer instruction.** Outputs are combinational from the inputs. Opcodes decoded:
  - R-type 0110011: ADD, SUB (funct7 0100000), AND, OR, SLT.
  - ADDI 0010011.
  - LW 0000011: ResultSrc=1, ALUSrc=1.
  - SW 0100011: MemWrite=1, ImmSrc=01.
  - BEQ/BNE 1100011: ALUControl=SUB, ImmSrc=10. PCSrc = Zero for BEQ, !Zero for BNE.
- **IDLE, FP instruction.** op 1010011 with funct7 0000000/0000100/0001000/0001100:
  - Latch FPUControl.
  - Assert stall in the same cycle; RegWrite=0.
  - Next state ISSUE.
- **ISSUE.** fpu_start = fpu_ready, stall=1. When fpu_ready=1, go to WAIT and clear the counter; otherwise stay.
- **WAIT.** stall=1. The counter increments each cycle.
  - fpu_done=1: go to WB.
  - Else if counter == TIMEOUT_CYCLES-1: set fpu_err, go to IDLE, no writeback.
  - If fpu_done arrives on the timeout cycle, done wins.
- **WB.** One cycle: RegWrite=1, ALU_FPU_Select=1, stall=0, FPUControl held. Next state IDLE.
- **illegal.** Pulses for one cycle in IDLE when instr_valid=1 and nothing decodes. All write enables stay 0.
- **instr_valid=0 in IDLE.** All enables 0 (NOP).
- **fpu_err.** Sticky; cleared only by RST.
- **Defaults.** Any output not driven by the current state/decode is 0.

## Timing
- RST low: all outputs 0 immediately (asynchronous), FSM forced to IDLE, any in-flight FP op discarded.
- Integer instructions: zero added latency, no stall.
- FP op latency = 1 (IDLE) + ISSUE cycles (≥1) + WAIT cycles until done + 1 (WB).
  - Minimum is 4 cycles, with fpu_ready=1 and done on the first WAIT cycle.
- fpu_done is sampled only in WAIT; done in any other state is ignored.
- fpu_start is high for exactly one cycle per accepted op.
- Counter saturates; it never wraps.

## Configuration
- FPU_DIV_EN defined: FDIV.S (funct7 0001100) decodes to FPUControl=3.
- FPU_DIV_EN undefined: FDIV.S pulses illegal, causes no stall and issues no FPU op.

## Test plan
- ADD x-type (op 0110011, f3 000, f7 0000000, instr_valid=1) -> same cycle: RegWrite=1, ALUControl=000, stall=0, ALU_FPU_Select=0.
- BNE with Zero=0 -> PCSrc=1. Same instruction with Zero=1 -> PCSrc=0.
- FMUL.S, fpu_ready=1, fpu_done 3 cycles after fpu_start:
  - fpu_start pulses once with FPUControl=2.
  - stall high for 5 cycles.
  - WB cycle: RegWrite=1, ALU_FPU_Select=1.
- FADD.S with fpu_ready=0 for 4 cycles -> FSM holds ISSUE, fpu_start=0, stall=1. fpu_start asserts on the cycle fpu_ready rises.
- TIMEOUT_CYCLES=8, FDIV.S, no fpu_done:
  - fpu_err rises after 8 WAIT cycles; FSM returns to IDLE; RegWrite never asserted.
  - Without FPU_DIV_EN: illegal=1 for one cycle, no stall.
- RST low during WAIT -> all outputs 0 and fpu_err=0 at once; after release a new ADD decodes normally.

Source files
------------

// File: rtl/fpu_seq_ctrl.sv
// Main decoder with a start/ready/done sequencer for a variable-latency RV32F FPU.
// Define FPU_DIV_EN to decode FDIV.S; otherwise it is reported as illegal.
module fpu_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int FPU_CTRL_W     = 3,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  instr_valid,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  Zero,
  input  logic                  fpu_ready,
  input  logic                  fpu_done,
  output logic                  PCSrc,
  output logic                  ResultSrc,
  output logic                  MemWrite,
  output logic [2:0]            ALUControl,
  output logic                  ALUSrc,
  output logic [1:0]            ImmSrc,
  output logic                  RegWrite,
  output logic [FPU_CTRL_W-1:0] FPUControl,
  output logic                  ALU_FPU_Select,
  output logic                  fpu_start,
  output logic                  stall,
  output logic                  illegal,
  output logic                  fpu_err
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_FP = 7'b1010011;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [FPU_CTRL_W-1:0] fctl_q, fctl_nxt;
  logic                  err_q, err_nxt;
  logic                  is_fp;
  logic [FPU_CTRL_W-1:0] fp_ctl;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state  <= S_IDLE;
      cnt    <= '0;
      fctl_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      fctl_q <= fctl_nxt;
      err_q  <= err_nxt;
    end
  end

  // FP funct7 encodes the operation in bits [3:2]
  always_comb begin
    is_fp  = 1'b0;
    fp_ctl = FPU_CTRL_W'(funct7[3:2]);
    if (op == OP_FP) begin
      case (funct7)
        7'b0000000, 7'b0000100, 7'b0001000: is_fp = 1'b1;
`ifdef FPU_DIV_EN
        7'b0001100: is_fp = 1'b1;
`else
        7'b0001100: is_fp = 1'b0;
`endif
        default: is_fp = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    fctl_nxt       = fctl_q;
    err_nxt        = err_q;
    PCSrc          = 1'b0;
    ResultSrc      = 1'b0;
    MemWrite       = 1'b0;
    ALUControl     = 3'b000;
    ALUSrc         = 1'b0;
    ImmSrc         = 2'b00;
    RegWrite       = 1'b0;
    FPUControl     = '0;
    ALU_FPU_Select = 1'b0;
    fpu_start      = 1'b0;
    stall          = 1'b0;
    illegal        = 1'b0;
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          if (is_fp) begin
            stall      = 1'b1;
            FPUControl = fp_ctl;
            fctl_nxt   = fp_ctl;
            state_nxt  = S_ISSUE;
          end else begin
            case (op)
              OP_R: begin
                RegWrite = 1'b1;
                case ({funct7, funct3})
                  {7'b0000000, 3'b000}: ALUControl = 3'b000;
                  {7'b0100000, 3'b000}: ALUControl = 3'b001;
                  {7'b0000000, 3'b111}: ALUControl = 3'b010;
                  {7'b0000000, 3'b110}: ALUControl = 3'b011;
                  {7'b0000000, 3'b010}: ALUControl = 3'b101;
                  default: begin
                    RegWrite = 1'b0;
                    illegal  = 1'b1;
                  end
                endcase
              end
              OP_I: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
              end
              OP_LW: begin
                RegWrite  = 1'b1;
                ALUSrc    = 1'b1;
                ResultSrc = 1'b1;
              end
              OP_SW: begin
                MemWrite = 1'b1;
                ALUSrc   = 1'b1;
                ImmSrc   = 2'b01;
              end
              OP_B: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) begin
                  ALUControl = 3'b001;
                  ImmSrc     = 2'b10;
                  PCSrc      = funct3[0] ? !Zero : Zero;
                end else begin
                  illegal = 1'b1;
                end
              end
              default: illegal = 1'b1;
            endcase
          end
        end
      end
      S_ISSUE: begin
        stall      = 1'b1;
        FPUControl = fctl_q;
        fpu_start  = fpu_ready;
        if (fpu_ready) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        stall      = 1'b1;
        FPUControl = fctl_q;
        if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
        // done on the timeout cycle still completes normally
        if (fpu_done) begin
          state_nxt = S_WB;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WB: begin
        RegWrite       = 1'b1;
        ALU_FPU_Select = 1'b1;
        FPUControl     = fctl_q;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    fpu_err = err_q;
    // reset forces every output low without waiting for a clock
    if (!RST) begin
      PCSrc          = 1'b0;
      ResultSrc      = 1'b0;
      MemWrite       = 1'b0;
      ALUControl     = 3'b000;
      ALUSrc         = 1'b0;
      ImmSrc         = 2'b00;
      RegWrite       = 1'b0;
      FPUControl     = '0;
      ALU_FPU_Select = 1'b0;
      fpu_start      = 1'b0;
      stall          = 1'b0;
      illegal        = 1'b0;
      fpu_err        = 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Bench for fpu_seq_ctrl: directed vectors, a transaction-level model checked every cycle.
module tb_fpu_seq_ctrl;

  localparam int TO = 8;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_FP = 7'b1010011;

  typedef struct packed {
    logic       pcsrc, resultsrc, memwrite;
    logic [2:0] aluctl;
    logic       alusrc;
    logic [1:0] immsrc;
    logic       regwrite;
    logic [2:0] fctl;
    logic       sel, start, stall, illegal, err;
  } outs_t;

  logic CLK, RST, instr_valid, Zero, fpu_ready, fpu_done;
  logic [6:0] op, funct7;
  logic [2:0] funct3;
  logic PCSrc, ResultSrc, MemWrite, ALUSrc, RegWrite, ALU_FPU_Select;
  logic fpu_start, stall, illegal, fpu_err;
  logic [2:0] ALUControl, FPUControl;
  logic [1:0] ImmSrc;

  fpu_seq_ctrl #(.TIMEOUT_CYCLES(TO), .FPU_CTRL_W(3)) dut (
    .CLK(CLK), .RST(RST), .instr_valid(instr_valid), .op(op), .funct3(funct3),
    .funct7(funct7), .Zero(Zero), .fpu_ready(fpu_ready), .fpu_done(fpu_done),
    .PCSrc(PCSrc), .ResultSrc(ResultSrc), .MemWrite(MemWrite), .ALUControl(ALUControl),
    .ALUSrc(ALUSrc), .ImmSrc(ImmSrc), .RegWrite(RegWrite), .FPUControl(FPUControl),
    .ALU_FPU_Select(ALU_FPU_Select), .fpu_start(fpu_start), .stall(stall),
    .illegal(illegal), .fpu_err(fpu_err)
  );

  outs_t act;
  assign act = {PCSrc, ResultSrc, MemWrite, ALUControl, ALUSrc, ImmSrc, RegWrite,
                FPUControl, ALU_FPU_Select, fpu_start, stall, illegal, fpu_err};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic fp_ok(input logic [6:0] o, input logic [6:0] f7);
    if (o != OP_FP) return 1'b0;
    if (f7 == 7'd0 || f7 == 7'd4 || f7 == 7'd8) return 1'b1;
`ifdef FPU_DIV_EN
    if (f7 == 7'd12) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic outs_t decode(input logic v, input logic [6:0] o, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic z);
    outs_t e = '0;
    if (!v) return e;
    if (fp_ok(o, f7)) begin
      e.stall = 1'b1;
      e.fctl  = {1'b0, f7[3:2]};
      return e;
    end
    if (o == OP_R && f7 == 7'd0 && f3 == 3'd0)       begin e.regwrite = 1; e.aluctl = 3'b000; end
    else if (o == OP_R && f7 == 7'h20 && f3 == 3'd0) begin e.regwrite = 1; e.aluctl = 3'b001; end
    else if (o == OP_R && f7 == 7'd0 && f3 == 3'd7)  begin e.regwrite = 1; e.aluctl = 3'b010; end
    else if (o == OP_R && f7 == 7'd0 && f3 == 3'd6)  begin e.regwrite = 1; e.aluctl = 3'b011; end
    else if (o == OP_R && f7 == 7'd0 && f3 == 3'd2)  begin e.regwrite = 1; e.aluctl = 3'b101; end
    else if (o == OP_I)  begin e.regwrite = 1; e.alusrc = 1; end
    else if (o == OP_LW) begin e.regwrite = 1; e.alusrc = 1; e.resultsrc = 1; end
    else if (o == OP_SW) begin e.memwrite = 1; e.alusrc = 1; e.immsrc = 2'b01; end
    else if (o == OP_B && f3 == 3'd0) begin e.aluctl = 3'b001; e.immsrc = 2'b10; e.pcsrc = z; end
    else if (o == OP_B && f3 == 3'd1) begin e.aluctl = 3'b001; e.immsrc = 2'b10; e.pcsrc = !z; end
    else e.illegal = 1'b1;
    return e;
  endfunction

  // An FP op is either waiting to be accepted, accepted and counting, or retiring.
  logic       m_busy, m_acc, m_wb, m_err;
  logic [2:0] m_ctrl;
  int         m_waited;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_busy <= 0; m_acc <= 0; m_wb <= 0; m_err <= 0; m_ctrl <= 0; m_waited <= 0;
    end else if (m_wb) begin
      m_wb <= 0;
    end else if (m_busy && !m_acc) begin
      if (fpu_ready) begin m_acc <= 1; m_waited <= 0; end
    end else if (m_busy) begin
      if (fpu_done) begin m_busy <= 0; m_wb <= 1; end
      else if (m_waited + 1 == TO) begin m_busy <= 0; m_err <= 1; end
      else m_waited <= m_waited + 1;
    end else if (instr_valid && fp_ok(op, funct7)) begin
      m_busy <= 1; m_acc <= 0; m_ctrl <= {1'b0, funct7[3:2]};
    end
  end

  function automatic outs_t expect_now();
    outs_t e = '0;
    if (!RST) return e;
    if (m_wb) begin e.regwrite = 1; e.sel = 1; e.fctl = m_ctrl; end
    else if (m_busy && !m_acc) begin e.stall = 1; e.start = fpu_ready; e.fctl = m_ctrl; end
    else if (m_busy) begin e.stall = 1; e.fctl = m_ctrl; end
    else e = decode(instr_valid, op, funct3, funct7, Zero);
    e.err = m_err;
    return e;
  endfunction

  always @(negedge CLK) chk("cycle", 32'(act), 32'(expect_now()));

  // ---------------- stimulus ----------------
  task automatic go(input logic v, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                    input logic z, input logic r, input logic d);
    @(posedge CLK); #1;
    instr_valid = v; op = o; funct3 = f3; funct7 = f7; Zero = z; fpu_ready = r; fpu_done = d;
    @(negedge CLK);
  endtask

  task automatic nop();
    go(0, 7'd0, 3'd0, 7'd0, 0, 0, 0);
  endtask

  int cnt_stall, cnt_start, cnt_rw;

  initial begin
    RST = 0; instr_valid = 1; op = OP_R; funct3 = 0; funct7 = 0; Zero = 0;
    fpu_ready = 0; fpu_done = 0;
    #2;
    chk("reset_outputs_zero", 32'(act), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST = 1;
    @(negedge CLK);

    go(1, OP_R, 3'd0, 7'd0, 0, 0, 0);
    chk("add_regwrite", RegWrite, 1);
    chk("add_aluctl", ALUControl, 3'b000);
    chk("add_stall", stall, 0);
    chk("add_sel", ALU_FPU_Select, 0);
    go(1, OP_R, 3'd0, 7'h20, 0, 0, 0);
    chk("sub_aluctl", ALUControl, 3'b001);
    go(1, OP_R, 3'd7, 7'd0, 0, 0, 0);
    go(1, OP_R, 3'd6, 7'd0, 0, 0, 0);
    go(1, OP_R, 3'd2, 7'd0, 0, 0, 0);
    chk("slt_aluctl", ALUControl, 3'b101);
    go(1, OP_I, 3'd0, 7'd0, 0, 0, 0);
    go(1, OP_LW, 3'd2, 7'd0, 0, 0, 0);
    chk("lw_resultsrc", ResultSrc, 1);
    go(1, OP_SW, 3'd2, 7'd0, 0, 0, 0);
    chk("sw_memwrite_imm", {MemWrite, ImmSrc, RegWrite}, 4'b1010);
    go(1, OP_B, 3'd1, 7'd0, 0, 0, 0);
    chk("bne_z0_pcsrc", PCSrc, 1);
    go(1, OP_B, 3'd1, 7'd0, 1, 0, 0);
    chk("bne_z1_pcsrc", PCSrc, 0);
    go(1, OP_B, 3'd0, 7'd0, 1, 0, 0);
    chk("beq_z1_pcsrc", PCSrc, 1);
    go(1, 7'b1111111, 3'd0, 7'd0, 0, 0, 0);
    chk("bad_op_illegal", {illegal, RegWrite, MemWrite}, 3'b100);
    go(1, OP_R, 3'd1, 7'd0, 0, 0, 1);
    nop();
    chk("nop_illegal", illegal, 0);

    // FMUL, done 3 cycles after start
    cnt_stall = 0; cnt_start = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) go(1, OP_FP, 3'd0, 7'd8, 0, 1, 0);
      else        go(0, 7'd0, 3'd0, 7'd0, 0, 1, i == 4);
      cnt_stall += int'(stall);
      if (fpu_start) begin
        cnt_start++;
        chk("fmul_start_ctl", FPUControl, 3'd2);
      end
      if (i == 5) chk("fmul_wb", {RegWrite, ALU_FPU_Select, stall}, 3'b110);
    end
    chk("fmul_stall_cycles", cnt_stall, 5);
    chk("fmul_start_pulses", cnt_start, 1);

    // FADD, FPU not ready for 4 cycles; a stray done during ISSUE is ignored
    go(1, OP_FP, 3'd0, 7'd0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      go(0, 7'd0, 3'd0, 7'd0, 0, 0, i == 2);
      chk("fadd_hold", {fpu_start, stall}, 2'b01);
    end
    go(0, 7'd0, 3'd0, 7'd0, 0, 1, 0);
    chk("fadd_start_on_ready", {fpu_start, FPUControl}, 4'b1000);
    go(0, 7'd0, 3'd0, 7'd0, 0, 0, 1);
    go(0, 7'd0, 3'd0, 7'd0, 0, 0, 0);
    chk("fadd_wb", {RegWrite, ALU_FPU_Select}, 2'b11);

    // FSUB, done arrives on the last WAIT cycle: done wins
    go(1, OP_FP, 3'd0, 7'd4, 0, 1, 0);
    go(0, 7'd0, 3'd0, 7'd0, 0, 1, 0);
    for (int i = 0; i < TO; i++) go(0, 7'd0, 3'd0, 7'd0, 0, 0, i == TO - 1);
    go(0, 7'd0, 3'd0, 7'd0, 0, 0, 0);
    chk("done_wins_wb", {RegWrite, fpu_err}, 2'b10);

    // FMUL, no done: watchdog
    cnt_rw = 0;
    go(1, OP_FP, 3'd0, 7'd8, 0, 1, 0);
    cnt_rw += int'(RegWrite);
    go(0, 7'd0, 3'd0, 7'd0, 0, 1, 0);
    cnt_rw += int'(RegWrite);
    for (int i = 0; i < TO; i++) begin
      go(0, 7'd0, 3'd0, 7'd0, 0, 0, 0);
      cnt_rw += int'(RegWrite);
    end
    chk("timeout_err_before", fpu_err, 0);
    nop();
    cnt_rw += int'(RegWrite);
    chk("timeout_err_after", {fpu_err, stall}, 2'b10);
    chk("timeout_no_regwrite", cnt_rw, 0);
    go(1, OP_R, 3'd0, 7'd0, 0, 0, 1);
    chk("err_sticky_add", {RegWrite, fpu_err}, 2'b11);

    // FDIV
    go(1, OP_FP, 3'd0, 7'd12, 0, 1, 0);
`ifdef FPU_DIV_EN
    chk("fdiv_decode", {stall, FPUControl, illegal}, 5'b10110);
    go(0, 7'd0, 3'd0, 7'd0, 0, 1, 0);
    go(0, 7'd0, 3'd0, 7'd0, 0, 0, 1);
    go(0, 7'd0, 3'd0, 7'd0, 0, 0, 0);
    chk("fdiv_wb", {RegWrite, FPUControl}, 4'b1011);
`else
    chk("fdiv_illegal", {illegal, stall, fpu_start, RegWrite}, 4'b1000);
    go(0, 7'd0, 3'd0, 7'd0, 0, 1, 0);
    chk("fdiv_no_issue", {illegal, stall, fpu_start}, 3'b000);
`endif

    // reset while an op is in WAIT
    go(1, OP_FP, 3'd0, 7'd8, 0, 1, 0);
    go(0, 7'd0, 3'd0, 7'd0, 0, 1, 0);
    go(1, OP_R, 3'd0, 7'd0, 0, 0, 0);
    chk("wait_stall_pre_rst", {stall, fpu_err}, 2'b11);
    #1 RST = 0;
    #1 chk("rst_async_zero", 32'(act), 32'd0);
    @(posedge CLK); #1 RST = 1;
    @(negedge CLK);
    chk("post_rst_add", {RegWrite, stall, fpu_err, ALUControl}, 6'b100000);
    nop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
